serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/result width in bits (SHALL be >= 2).
REQ-002 clk  input  1  rising-edge clock; one clock domain only.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request one addition; sampled only while ready=1.
REQ-005 a_in  input  WIDTH  operand A; captured on the accepted start.
REQ-006 b_in  input  WIDTH  operand B; captured on the accepted start.
REQ-007 cin  input  1  carry-in; captured on the accepted start.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 done  output  1  one-cycle pulse when the result is complete.
REQ-010 sum_out  output  WIDTH  result, held stable from done until the next accepted start.
REQ-011 cout  output  1  final carry-out, held with sum_out.

Function
REQ-012 The block SHALL perform the addition bit-serially, LSB first, through one single-bit full adder, one bit per clock.
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE -> SHIFT on the edge where start=1. That edge SHALL load the A/B shift registers, load the carry register with cin, and clear the bit counter.
REQ-015 Each SHIFT edge SHALL:
- feed the LSBs of A and B plus the carry register into the full adder;
- shift the sum bit into the result register at the MSB;
- shift A and B right by one;
- update the carry register with the adder carry;
- increment the counter.
REQ-016 SHIFT -> DONE after exactly WIDTH SHIFT edges; counter width SHALL be $clog2(WIDTH+1) bits, with no wrap before the transition.
REQ-017 DONE -> IDLE unconditionally on the next edge; done=1 only while in DONE.
REQ-018 Latency SHALL be WIDTH+1 edges from the start-accept edge to the done cycle; throughput is one addition per WIDTH+2 cycles.
REQ-019 sum_out SHALL equal (a_in + b_in + cin) mod 2^WIDTH and cout SHALL equal bit WIDTH of that sum, both valid in the done cycle.
REQ-020 start while ready=0 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-021 Operand inputs SHALL be ignored outside the accept edge; changing them mid-operation SHALL NOT alter the result.
REQ-022 start held high continuously SHALL start a new addition on each IDLE cycle, i.e. back-to-back operations WIDTH+2 cycles apart.

Reset
REQ-023 rst_n=0 SHALL immediately force:
- state to IDLE and ready=1;
- done=0, sum_out=0, cout=0;
- counter, shift registers and carry register to 0;
- ovf=0 where that port is present.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-025 Macro SERIAL_ADD_OVF_EN.
- Defined: an output ovf (1 bit) exists, equal to the signed two's-complement overflow (carry into MSB XOR carry out of MSB). ovf SHALL be registered in the last SHIFT cycle and held with sum_out.
- Undefined: no ovf port and no related logic.

Structure
REQ-026 Package serial_add_pkg SHALL hold the FSM state enum typedef (IDLE, SHIFT, DONE) and the default-width constant.
REQ-027 Sub-module full_adder_bit (inputs a, b, c; outputs sum, carry; purely combinational) SHALL be instantiated exactly once as the datapath.

Verification
REQ-028 The bench SHALL cover these directed scenarios, with WIDTH=8:
- 0x0F + 0x01, cin=0 -> done 9 edges after accept; sum_out=0x10, cout=0.
- 0xFF + 0x01, cin=0 -> sum_out=0x00, cout=1 (ovf=0 when enabled).
- 0x7F + 0x01, cin=0 -> sum_out=0x80, cout=0, ovf=1 when SERIAL_ADD_OVF_EN is defined.
- 0x00 + 0x00, cin=1 -> sum_out=0x01. Then pulse start with 0xAA + 0x55 during SHIFT -> ignored; first result unchanged and no extra done.
- Start 0x12 + 0x34, assert rst_n=0 after 3 SHIFT cycles -> all outputs 0 and ready=1 immediately, no done. After release, 0x12 + 0x34 -> sum_out=0x46.
- Exhaustive 1-bit check via the sub-module: all 8 (a, b, c) combinations of full_adder_bit -> sum=a^b^c, carry=majority.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM state type and default width for the serial adder
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for serial_add_ctrl (ovf present under SERIAL_ADD_OVF_EN)
interface serial_add_ctrl_if import serial_add_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a_in, b_in, cin,
                  input  ready, done, sum_out, cout, ovf);
  modport slave  (input  start, a_in, b_in, cin,
                  output ready, done, sum_out, cout, ovf);
`else
  modport master (output start, a_in, b_in, cin,
                  input  ready, done, sum_out, cout);
  modport slave  (input  start, a_in, b_in, cin,
                  output ready, done, sum_out, cout);
`endif

endinterface

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit combinational full adder
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial LSB-first adder with IDLE/SHIFT/DONE control (ovf under SERIAL_ADD_OVF_EN)
module serial_add_ctrl import serial_add_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ready_q;
  logic             done_q;
  logic             fa_sum;
  logic             fa_carry;

  // The only arithmetic in the block: one bit of A, B and the running carry.
  full_adder_bit u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Carry into the MSB is the carry register during the last shift; XOR with the carry out gives signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == SHIFT && cnt == LAST) begin
      ovf_q <= carry ^ fa_carry;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  // Control FSM and datapath registers; sum_q doubles as the result shift register, so it only moves after an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.a_in;
            b_sh    <= bus.b_in;
            carry   <= bus.cin;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sum_q <= {fa_sum, sum_q[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fa_carry;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_q <= fa_carry;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.sum_out = sum_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl and full_adder_bit (honours SERIAL_ADD_OVF_EN)
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total  = 0;
  int   passed = 0;
  exp_t sb[$];

  logic fa_a, fa_b, fa_c, fa_s, fa_co;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  full_adder_bit u_fa (
    .a     (fa_a),
    .b     (fa_b),
    .c     (fa_c),
    .sum   (fa_s),
    .carry (fa_co)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    exp_t       e;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    sb.push_back(model(a, b, c));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.ready); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else passed++;
    total++; if (bus.sum_out !== 8'h00) $display("FAIL reset_sum got=%h exp=00", bus.sum_out); else passed++;
    total++; if (bus.cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", bus.cout); else passed++;
`ifdef SERIAL_ADD_OVF_EN
    total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.ovf); else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [W-1:0] ta [3];
    logic [W-1:0] tb_ [3];
    int   e;
    bit   ok;
    exp_t x;
    ta  = '{8'h0F, 8'hFF, 8'h7F};
    tb_ = '{8'h01, 8'h01, 8'h01};
    for (int i = 0; i < 3; i++) begin
      do_start(ta[i], tb_[i], 1'b0);
      wait_done(e, ok);
      x = sb.pop_front();
      total++; if (!ok || (e + 1) != W + 1) $display("FAIL basic_latency op=%0d got=%0d exp=%0d", i, e + 1, W + 1); else passed++;
      total++; if (bus.sum_out !== x.sum) $display("FAIL basic_sum op=%0d got=%h exp=%h", i, bus.sum_out, x.sum); else passed++;
      total++; if (bus.cout !== x.cout) $display("FAIL basic_cout op=%0d got=%b exp=%b", i, bus.cout, x.cout); else passed++;
`ifdef SERIAL_ADD_OVF_EN
      total++; if (bus.ovf !== x.ovf) $display("FAIL basic_ovf op=%0d got=%b exp=%b", i, bus.ovf, x.ovf); else passed++;
`endif
      @(posedge clk);
      #1;
      total++; if (bus.done !== 1'b0) $display("FAIL done_pulse op=%0d got=%b exp=0", i, bus.done); else passed++;
      total++; if (bus.ready !== 1'b1) $display("FAIL ready_after op=%0d got=%b exp=1", i, bus.ready); else passed++;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.sum_out !== x.sum) $display("FAIL sum_hold op=%0d got=%h exp=%h", i, bus.sum_out, x.sum); else passed++;
    end
  endtask

  task automatic test_ignore_start;
    int   e;
    bit   ok;
    bit   extra;
    exp_t x;
    do_start(8'h00, 8'h00, 1'b1);
    @(negedge clk);
    bus.a_in  = 8'hAA;
    bus.b_in  = 8'h55;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_in  = 8'hFF;
    wait_done(e, ok);
    x = sb.pop_front();
    total++; if (!ok || (e + 2) != W + 1) $display("FAIL ignore_latency got=%0d exp=%0d", e + 2, W + 1); else passed++;
    total++; if (bus.sum_out !== x.sum) $display("FAIL ignore_sum got=%h exp=%h", bus.sum_out, x.sum); else passed++;
    total++; if (bus.cout !== x.cout) $display("FAIL ignore_cout got=%b exp=%b", bus.cout, x.cout); else passed++;
    extra = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra = 1'b1;
    end
    total++; if (extra) $display("FAIL ignore_extra_done got=1 exp=0"); else passed++;
    total++; if (bus.sum_out !== x.sum) $display("FAIL ignore_sum_hold got=%h exp=%h", bus.sum_out, x.sum); else passed++;
  endtask

  task automatic test_reset_mid;
    int   e;
    bit   ok;
    bit   seen;
    exp_t x;
    do_start(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    total++; if (bus.ready !== 1'b1) $display("FAIL abort_ready got=%b exp=1", bus.ready); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL abort_done got=%b exp=0", bus.done); else passed++;
    total++; if (bus.sum_out !== 8'h00) $display("FAIL abort_sum got=%h exp=00", bus.sum_out); else passed++;
    total++; if (bus.cout !== 1'b0) $display("FAIL abort_cout got=%b exp=0", bus.cout); else passed++;
`ifdef SERIAL_ADD_OVF_EN
    total++; if (bus.ovf !== 1'b0) $display("FAIL abort_ovf got=%b exp=0", bus.ovf); else passed++;
`endif
    seen = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL abort_no_done got=1 exp=0"); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    do_start(8'h12, 8'h34, 1'b0);
    wait_done(e, ok);
    x = sb.pop_front();
    total++; if (!ok || (e + 1) != W + 1) $display("FAIL rerun_latency got=%0d exp=%0d", e + 1, W + 1); else passed++;
    total++; if (bus.sum_out !== x.sum) $display("FAIL rerun_sum got=%h exp=%h", bus.sum_out, x.sum); else passed++;
    total++; if (bus.cout !== x.cout) $display("FAIL rerun_cout got=%b exp=%b", bus.cout, x.cout); else passed++;
    @(posedge clk);
  endtask

  task automatic test_back_to_back;
    int   issued;
    int   got;
    int   last;
    exp_t x;
    logic [W-1:0] a, b;
    logic c;
    issued = 0;
    got    = 0;
    last   = -1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      if (bus.ready === 1'b1) begin
        if (issued < 4) begin
          a = W'($urandom);
          b = W'($urandom);
          c = 1'($urandom);
          bus.a_in = a;
          bus.b_in = b;
          bus.cin  = c;
          sb.push_back(model(a, b, c));
          issued++;
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        bus.a_in = W'($urandom);
        bus.b_in = W'($urandom);
        bus.cin  = 1'($urandom);
      end
      if (bus.done === 1'b1) begin
        x = sb.pop_front();
        total++; if (bus.sum_out !== x.sum) $display("FAIL b2b_sum op=%0d got=%h exp=%h", got, bus.sum_out, x.sum); else passed++;
        total++; if (bus.cout !== x.cout) $display("FAIL b2b_cout op=%0d got=%b exp=%b", got, bus.cout, x.cout); else passed++;
`ifdef SERIAL_ADD_OVF_EN
        total++; if (bus.ovf !== x.ovf) $display("FAIL b2b_ovf op=%0d got=%b exp=%b", got, bus.ovf, x.ovf); else passed++;
`endif
        if (last >= 0) begin
          total++; if (cyc - last != W + 2) $display("FAIL b2b_spacing op=%0d got=%0d exp=%0d", got, cyc - last, W + 2); else passed++;
        end
        last = cyc;
        got++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    total++; if (got != 4) $display("FAIL b2b_count got=%0d exp=4", got); else passed++;
    repeat (W + 4) @(posedge clk);
  endtask

  task automatic test_full_adder;
    int n;
    for (int i = 0; i < 8; i++) begin
      fa_a = i[2];
      fa_b = i[1];
      fa_c = i[0];
      #1;
      n = int'(fa_a) + int'(fa_b) + int'(fa_c);
      total++; if (fa_s !== 1'(n % 2)) $display("FAIL fa_sum abc=%0d got=%b exp=%0d", i, fa_s, n % 2); else passed++;
      total++; if (fa_co !== 1'(n / 2)) $display("FAIL fa_carry abc=%0d got=%b exp=%0d", i, fa_co, n / 2); else passed++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.cin   = 1'b0;
    fa_a = 1'b0;
    fa_b = 1'b0;
    fa_c = 1'b0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_full_adder();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
